// File: rtl/lane_deskew_calibrator.sv
// lane_deskew_calibrator
//   Trains the IDELAY tap of each Camera Link LVDS receive lane, one lane at a
//   time. Each lane's tap is swept from 0 to MAX_TAP in TAP_STEP increments.
//   At every point the deserialized byte is compared against TRAIN_PATTERN for
//   CHECK_CYC cycles. The centre of the longest contiguous passing window
//   becomes the lane's final tap. A lane whose widest eye is narrower than
//   MIN_EYE falls back to DEFAULT_TAP and is flagged as failed.
//
// Ports
//   i_clk         parallel (ISERDES output) clock
//   i_rst         synchronous active-high reset
//   i_start       single-cycle calibration request, accepted only in IDLE
//   i_idelay_rdy  IDELAYCTRL ready; when it falls mid-sweep the lane restarts
//   i_lane_data   deserialized bytes, lane n at [n*8 +: 8]
//   o_tap_load    one-cycle strobe: load o_tap_value into lane o_tap_lane
//   o_tap_lane    lane index for the load strobe
//   o_tap_value   tap value for the load strobe
//   o_taps        committed final tap per lane, lane n at [n*TAP_W +: TAP_W]
//   o_busy        calibration in progress
//   o_done        calibration complete, held until the next accepted start
//   o_lane_fail   per-lane flag: eye narrower than MIN_EYE
module lane_deskew_calibrator #(
    parameter int         NUM_LANES     = 11,
    parameter int         TAP_W         = 9,
    parameter int         MAX_TAP       = 511,
    parameter int         TAP_STEP      = 8,
    parameter int         SETTLE_CYC    = 16,
    parameter int         CHECK_CYC     = 64,
    parameter logic [7:0] TRAIN_PATTERN = 8'hA5,
    parameter int         MIN_EYE       = 4,
    parameter int         DEFAULT_TAP   = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_idelay_rdy,
    input  logic [NUM_LANES*8-1:0]     i_lane_data,
    output logic                       o_tap_load,
    output logic [3:0]                 o_tap_lane,
    output logic [TAP_W-1:0]           o_tap_value,
    output logic [NUM_LANES*TAP_W-1:0] o_taps,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [NUM_LANES-1:0]       o_lane_fail
);

    localparam int NPTS    = MAX_TAP / TAP_STEP + 1;
    localparam int LEN_W   = $clog2(NPTS + 1);
    localparam int TW1     = TAP_W + 1;
    localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYC - 1);
    localparam logic [3:0]       LAST_LANE   = 4'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, SET_TAP, SETTLE, CHECK, EVAL, CENTER, DONE
    } state_t;

    state_t             state;
    logic [3:0]         lane;
    logic [TAP_W-1:0]   tap;
    logic [CNT_W-1:0]   cnt;
    logic               mis;
    logic [TAP_W-1:0]   cur_start;
    logic [LEN_W-1:0]   cur_len;
    logic [TAP_W-1:0]   best_start;
    logic [LEN_W-1:0]   best_len;

    logic [7:0]         lane_byte;
    logic [TAP_W-1:0]   new_start;
    logic [LEN_W-1:0]   new_len;
    logic               last_point;
    logic               eye_ok;
    logic [TAP_W-1:0]   final_tap;

    // Window centre, floored; span is computed one bit wider than a tap so
    // the intermediate product cannot wrap.
    function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] start,
                                                    input logic [LEN_W-1:0] len);
        logic [TW1-1:0] span;
        logic [TW1-1:0] sum;
        span = TW1'(len - 1'b1) * TW1'(TAP_STEP);
        sum  = {1'b0, start} + (span >> 1);
        return TAP_W'(sum);
    endfunction

    always_comb begin
        lane_byte  = i_lane_data[{lane, 3'b000} +: 8];
        new_start  = (cur_len == '0) ? tap : cur_start;
        new_len    = cur_len + 1'b1;
        last_point = ({1'b0, tap} + TW1'(TAP_STEP)) > TW1'(MAX_TAP);
        eye_ok     = best_len >= LEN_W'(MIN_EYE);
        final_tap  = eye_ok ? center_tap(best_start, best_len) : TAP_W'(DEFAULT_TAP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_tap_load  <= 1'b0;
            o_tap_lane  <= '0;
            o_tap_value <= '0;
            o_taps      <= {NUM_LANES{TAP_W'(DEFAULT_TAP)}};
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_lane_fail <= '0;
        end else begin
            o_tap_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_lane_fail <= '0;
                        lane        <= '0;
                        o_busy      <= 1'b1;
                        state       <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (i_idelay_rdy) begin
                        tap        <= '0;
                        cur_start  <= '0;
                        cur_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                        state      <= SET_TAP;
                    end
                end
                SET_TAP: begin
                    if (!i_idelay_rdy) begin
                        state <= WAIT_RDY;
                    end else begin
                        o_tap_load  <= 1'b1;
                        o_tap_lane  <= lane;
                        o_tap_value <= tap;
                        cnt         <= '0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!i_idelay_rdy) begin
                        state <= WAIT_RDY;
                    end else if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        mis   <= 1'b0;
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!i_idelay_rdy) begin
                        state <= WAIT_RDY;
                    end else begin
                        // Sticky: one bad sample fails the whole point.
                        mis <= mis | (lane_byte != TRAIN_PATTERN);
                        if (cnt == CHECK_LAST) state <= EVAL;
                        else                   cnt   <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (!i_idelay_rdy) begin
                        state <= WAIT_RDY;
                    end else begin
                        if (!mis) begin
                            cur_start <= new_start;
                            cur_len   <= new_len;
                            // Strict compare keeps the earliest of equal windows.
                            if (new_len > best_len) begin
                                best_start <= new_start;
                                best_len   <= new_len;
                            end
                        end else begin
                            cur_len <= '0;
                        end
                        if (last_point) begin
                            state <= CENTER;
                        end else begin
                            tap   <= tap + TAP_W'(TAP_STEP);
                            state <= SET_TAP;
                        end
                    end
                end
                CENTER: begin
                    o_tap_load                      <= 1'b1;
                    o_tap_lane                      <= lane;
                    o_tap_value                     <= final_tap;
                    o_taps[lane*TAP_W +: TAP_W]     <= final_tap;
                    if (!eye_ok) o_lane_fail[lane]  <= 1'b1;
                    if (lane == LAST_LANE) begin
                        state <= DONE;
                    end else begin
                        lane       <= lane + 1'b1;
                        tap        <= '0;
                        cur_start  <= '0;
                        cur_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                        state      <= SET_TAP;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_deskew_calibrator.sv
// Bench for lane_deskew_calibrator. Settle/check windows are shortened so that
// several complete calibrations fit in a short run; tap range, step and lane
// count stay at their production values so window centres are unchanged.
module tb_lane_deskew_calibrator;

    localparam int NL      = 11;
    localparam int TW      = 9;
    localparam int S       = 2;
    localparam int C       = 4;
    localparam int NPTS    = 64;
    localparam int EXP_LAT = 2 + NL * (NPTS * (2 + S + C) + 1);
    localparam int BOUND   = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rdy;
    logic [NL*8-1:0]   lane_data;
    logic              tap_load;
    logic [3:0]        tap_lane;
    logic [TW-1:0]     tap_value;
    logic [NL*TW-1:0]  taps;
    logic              busy;
    logic              done;
    logic [NL-1:0]     lane_fail;

    always #5 clk = ~clk;

    lane_deskew_calibrator #(
        .NUM_LANES(NL), .TAP_W(TW), .SETTLE_CYC(S), .CHECK_CYC(C)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_idelay_rdy(rdy),
        .i_lane_data(lane_data), .o_tap_load(tap_load), .o_tap_lane(tap_lane),
        .o_tap_value(tap_value), .o_taps(taps), .o_busy(busy), .o_done(done),
        .o_lane_fail(lane_fail)
    );

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    bit glitch   = 1'b0;
    int load_cnt = 0;
    int since_load = 0;
    logic [TW-1:0] applied [16];
    logic [7:0]    lb;

    // Lane eye model: does lane l see the pattern with tap t applied?
    function automatic bit lane_pass(input int m, input int l, input int t);
        case (m)
            1: return (l != 3) || (t >= 128 && t <= 248);
            2: begin
                if (l == 5)      return 1'b0;
                else if (l == 6) return t <= 16;
                else             return 1'b1;
            end
            3: return (l != 0) || (t <= 56) || (t >= 200 && t <= 256);
            default: return 1'b1;
        endcase
    endfunction

    // Lane front-end model: tracks the tap applied per lane and drives bytes.
    always @(negedge clk) begin
        if (tap_load) begin
            applied[tap_lane] = tap_value;
            since_load = 0;
            load_cnt++;
        end else begin
            since_load++;
        end
        for (int l = 0; l < NL; l++) begin
            lb = lane_pass(mode, l, int'(applied[l])) ? 8'hA5 : 8'h5A;
            if (glitch && l == 0 && applied[0] == 9'd32 && since_load == S + 1)
                lb = 8'h24;
            lane_data[l*8 +: 8] = lb;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [NL*TW-1:0] all_taps(input logic [TW-1:0] v);
        logic [NL*TW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*TW +: TW] = v;
        return r;
    endfunction

    task automatic check_taps(input string tag, input logic [NL*TW-1:0] exp);
        for (int l = 0; l < NL; l++)
            check($sformatf("%s_tap%0d", tag, l), taps[l*TW +: TW], exp[l*TW +: TW]);
    endtask

    // Pulse start, then count cycles until o_done; optional second start.
    task automatic run_cal(input int repulse_at, output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= BOUND; k++) begin
            @(posedge clk); #1;
            start = (k == repulse_at);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_load(input int lane_want, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk); #1;
            if (tap_load && (lane_want < 0 || int'(tap_lane) == lane_want)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int               mode;
        bit               glitch;
        int               repulse_at;
        logic [NL*TW-1:0] exp_taps;
        logic [NL-1:0]    exp_fail;
    } vec_t;

    vec_t tv [5];

    initial begin
        int lat;
        int snap;
        bit ok;

        tv[0] = '{0, 1'b0, 0,   all_taps(9'd252), '0};
        tv[1] = '{1, 1'b0, 300, all_taps(9'd252), '0};
        tv[1].exp_taps[3*TW +: TW] = 9'd188;
        tv[2] = '{2, 1'b0, 0,   all_taps(9'd252), 11'b000_0110_0000};
        tv[2].exp_taps[5*TW +: TW] = 9'd256;
        tv[2].exp_taps[6*TW +: TW] = 9'd256;
        tv[3] = '{3, 1'b0, 0,   all_taps(9'd252), '0};
        tv[3].exp_taps[0 +: TW] = 9'd28;
        tv[4] = '{3, 1'b1, 0,   all_taps(9'd252), '0};
        tv[4].exp_taps[0 +: TW] = 9'd228;

        for (int i = 0; i < 16; i++) applied[i] = '0;
        rst = 1'b1; start = 1'b0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load", tap_load, 0);
        check("rst_lane", tap_lane, 0);
        check("rst_value", tap_value, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", lane_fail, 0);
        check_taps("rst", all_taps(9'd256));
        rst = 1'b0;
        @(posedge clk); #1;

        // Full calibrations from the vector table.
        for (int v = 0; v < 5; v++) begin
            mode = tv[v].mode;
            glitch = tv[v].glitch;
            load_cnt = 0;
            run_cal(tv[v].repulse_at, lat);
            check($sformatf("v%0d_latency", v), lat, EXP_LAT);
            check_taps($sformatf("v%0d", v), tv[v].exp_taps);
            check($sformatf("v%0d_fail", v), lane_fail, tv[v].exp_fail);
            check($sformatf("v%0d_busy", v), busy, 0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_done_held", v), done, 1);
            check($sformatf("v%0d_loads", v), load_cnt, (NPTS + 1) * NL);
        end
        glitch = 1'b0;

        // i_idelay_rdy drops for 10 cycles partway through lane 2.
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_load(2, ok);
        check("drop_reach_lane2", ok, 1);
        repeat (100) @(posedge clk);
        #1;
        rdy = 1'b0;
        snap = load_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("drop_busy", busy, 1);
        check("drop_no_loads", load_cnt, snap);
        rdy = 1'b1;
        wait_load(-1, ok);
        check("drop_reload_seen", ok, 1);
        check("drop_reload_lane", tap_lane, 2);
        check("drop_reload_value", tap_value, 0);
        check("drop_lane0_kept", taps[0 +: TW], 252);
        check("drop_lane1_kept", taps[TW +: TW], 252);
        ok = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("drop_done", ok, 1);
        check_taps("drop", all_taps(9'd252));
        check("drop_fail", lane_fail, 0);

        // Reset partway through lane 4 after a run that left lanes 0-3 committed
        // at 252 and lanes 5,6 failed.
        mode = 2;
        run_cal(0, lat);
        check("pre_rst_fail", lane_fail, 11'b000_0110_0000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_load(4, ok);
        check("rst_reach_lane4", ok, 1);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_fail", lane_fail, 0);
        check("midrst_load", tap_load, 0);
        check_taps("midrst", all_taps(9'd256));
        rst = 1'b0;
        @(posedge clk); #1;

        // Recovery after the mid-run reset.
        mode = 0;
        run_cal(0, lat);
        check("recover_latency", lat, EXP_LAT);
        check_taps("recover", all_taps(9'd252));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
